// File: rtl/rns_small_lift_pkg.sv
// rns_small_pkg: shared FSM states, ternary code points and the coefficient decoder.
package rns_small_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    localparam logic [1:0] TERN_ZERO = 2'b00;
    localparam logic [1:0] TERN_POS = 2'b01;
    localparam logic [1:0] TERN_NEG = 2'b11;
    localparam logic [1:0] TERN_BAD = 2'b10;
    localparam int MAX_CW = 16;
    typedef struct packed {
        logic signed [MAX_CW-1:0] x;
        logic err;
    } dec_t;
    // code arrives already sign-extended; ternary mode only looks at its low two bits
    function automatic dec_t decode_coeff(input logic signed [MAX_CW-1:0] code, input logic ternary);
        logic [1:0] c;
        dec_t d;
        c = code[1:0];
        d.err = ternary && c == TERN_BAD;
        d.x = !ternary ? code : (c == TERN_ZERO || c == TERN_BAD) ? '0 : (c == TERN_POS) ? MAX_CW'(1) : '1;
        return d;
    endfunction
endpackage

// File: rtl/rns_small_lift_if.sv
// rns_small_lift_if: configuration, control, source-read and destination-write bus of the lifter.
interface rns_small_lift_if #(
    parameter int LOGN = 13,
    parameter int LOGQ = 54,
    parameter int LOGI = 4,
    parameter int NUM_CH = 3,
    parameter int CW = 6
);
    logic cfg_we;
    logic [LOGI-1:0] cfg_idx;
    logic [LOGQ-1:0] cfg_q;
    logic start;
    logic [LOGI-1:0] mod_first;
    logic [LOGI:0] mod_count;
    logic [NUM_CH-1:0] ch_ternary;
    logic [LOGN-1:0] src_rd_addr;
    logic [NUM_CH*CW-1:0] src_rd_data;
    logic [LOGN-1:0] dst_wr_addr;
    logic [LOGI-1:0] dst_wr_mod;
    logic [NUM_CH*LOGQ-1:0] dst_wr_data;
    logic dst_wea;
    logic busy;
    logic done;
    logic code_err;
    modport master(
        output cfg_we, cfg_idx, cfg_q, start, mod_first, mod_count, ch_ternary, src_rd_data,
        input src_rd_addr, dst_wr_addr, dst_wr_mod, dst_wr_data, dst_wea, busy, done, code_err
    );
    modport slave(
        input cfg_we, cfg_idx, cfg_q, start, mod_first, mod_count, ch_ternary, src_rd_data,
        output src_rd_addr, dst_wr_addr, dst_wr_mod, dst_wr_data, dst_wea, busy, done, code_err
    );
endinterface

// File: rtl/rns_small_lift_lane.sv
// rns_lift_lane: one channel's decode of a small signed coefficient and its registered lift into [0, q).
module rns_lift_lane
    import rns_small_pkg::*;
#(
    parameter int CW = 6,
    parameter int LOGQ = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ternary,
    input  logic [CW-1:0] code,
    input  logic [LOGQ-1:0] q,
    output logic [LOGQ-1:0] residue,
    output logic err
);
    dec_t d;
    logic signed [MAX_CW-1:0] x;
    logic [LOGQ-1:0] xe;
    assign d = decode_coeff(MAX_CW'(signed'(code)), ternary);
    assign x = d.x;
    assign err = d.err;
    assign xe = LOGQ'(x);
    always_ff @(posedge clk) begin
        if (rst) residue <= '0;
        else if (en) residue <= x[MAX_CW-1] ? q + xe : xe;
    end
endmodule

// File: rtl/rns_small_lift.sv
// rns_small_lift: sweeps small signed source polys through a run-time modulus table into per-channel residues.
module rns_small_lift
    import rns_small_pkg::*;
#(
    parameter int N = 8192,
    parameter int LOGN = 13,
    parameter int LOGQ = 54,
    parameter int LOGI = 4,
    parameter int NUM_CH = 3,
    parameter int CW = 6,
    parameter int RD_LAT = 1
) (
    input logic clk,
    input logic rst,
    rns_small_lift_if.slave bus
);
    localparam int NUM_MOD = 2 ** LOGI;
    localparam int CNTW = $clog2(RD_LAT + 2);
    state_t state, state_n;
    logic [LOGQ-1:0] qtab [NUM_MOD];
    logic [LOGN-1:0] addr;
    logic [LOGI-1:0] k;
    logic [LOGI:0] rem;
    logic [NUM_CH-1:0] tern;
    logic [CNTW-1:0] cnt;
    logic tag_v [RD_LAT];
    logic [LOGN-1:0] tag_a [RD_LAT];
    logic [LOGI-1:0] tag_k [RD_LAT];
    logic [NUM_CH-1:0] err;
    logic [LOGQ-1:0] res [NUM_CH];
    logic last, wea, done;
    logic [LOGN-1:0] wr_addr;
    logic [LOGI-1:0] wr_mod;
    logic code_err;
    assign last = addr == LOGN'(N - 1);
    assign bus.src_rd_addr = addr;
    assign bus.dst_wea = wea;
    assign bus.dst_wr_addr = wr_addr;
    assign bus.dst_wr_mod = wr_mod;
    assign bus.done = done;
    assign bus.code_err = code_err;
    assign bus.busy = state == RUN || state == DRAIN;
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.start) state_n = (bus.mod_count == '0) ? FIN : RUN;
            RUN: if (last && rem == (LOGI+1)'(1)) state_n = DRAIN;
            DRAIN: if (cnt == CNTW'(RD_LAT)) state_n = FIN;
            FIN: state_n = IDLE;
        endcase
    end
    // table only changes between sweeps, so the lanes can read it combinationally
    always_ff @(posedge clk) begin
        if (bus.cfg_we && state == IDLE) qtab[bus.cfg_idx] <= bus.cfg_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr <= '0;
            k <= '0;
            rem <= '0;
            tern <= '0;
            cnt <= '0;
            done <= 1'b0;
            code_err <= 1'b0;
            wea <= 1'b0;
            wr_addr <= '0;
            wr_mod <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_v[i] <= 1'b0;
                tag_a[i] <= '0;
                tag_k[i] <= '0;
            end
        end else begin
            state <= state_n;
            done <= state == FIN;
            cnt <= (state == DRAIN) ? cnt + 1'b1 : '0;
            if (state == IDLE && bus.start) begin
                addr <= '0;
                k <= bus.mod_first;
                rem <= bus.mod_count;
                tern <= bus.ch_ternary;
            end
            if (state == RUN) begin
                addr <= last ? '0 : addr + 1'b1;
                if (last) begin
                    k <= k + 1'b1;
                    rem <= rem - 1'b1;
                end
            end
            tag_v[0] <= state == RUN;
            tag_a[0] <= addr;
            tag_k[0] <= k;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_a[i] <= tag_a[i-1];
                tag_k[i] <= tag_k[i-1];
            end
            wea <= tag_v[RD_LAT-1];
            wr_addr <= tag_a[RD_LAT-1];
            wr_mod <= tag_k[RD_LAT-1];
            code_err <= code_err | (tag_v[RD_LAT-1] & |err);
        end
    end
    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        rns_lift_lane #(.CW(CW), .LOGQ(LOGQ)) u_lane (
            .clk(clk),
            .rst(rst),
            .en(tag_v[RD_LAT-1]),
            .ternary(tern[c]),
            .code(bus.src_rd_data[c*CW +: CW]),
            .q(qtab[tag_k[RD_LAT-1]]),
            .residue(res[c]),
            .err(err[c])
        );
        assign bus.dst_wr_data[c*LOGQ +: LOGQ] = res[c];
    end
endmodule

// File: tb/tb_rns_small_lift.sv
// tb_rns_small_lift: randomized sweeps against a behavioural model, checked by a write-port scoreboard.
module tb_rns_small_lift;
    localparam int N = 16;
    localparam int LOGN = 4;
    localparam int LOGQ = 54;
    localparam int LOGI = 4;
    localparam int NUM_CH = 3;
    localparam int CW = 6;
    localparam int RD_LAT = 1;
    typedef struct {
        logic [LOGN-1:0] a;
        logic [LOGI-1:0] m;
        logic [NUM_CH*LOGQ-1:0] d;
    } exp_t;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    rns_small_lift_if #(.LOGN(LOGN), .LOGQ(LOGQ), .LOGI(LOGI), .NUM_CH(NUM_CH), .CW(CW)) bus();
    rns_small_lift #(.N(N), .LOGN(LOGN), .LOGQ(LOGQ), .LOGI(LOGI), .NUM_CH(NUM_CH), .CW(CW), .RD_LAT(RD_LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    logic [NUM_CH*CW-1:0] src_mem [N];
    logic [LOGQ-1:0] qm [2**LOGI];
    exp_t sb [$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    bit exp_err = 0;
    always @(posedge clk) bus.src_rd_data <= src_mem[bus.src_rd_addr];
    always @(negedge clk) begin
        if (bus.dst_wea === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr %0d mod %0d", bus.dst_wr_addr, bus.dst_wr_mod);
            end else begin
                mon_e = sb.pop_front();
                if (bus.dst_wr_addr !== mon_e.a || bus.dst_wr_mod !== mon_e.m || bus.dst_wr_data !== mon_e.d) begin
                    errors++;
                    $display("FAIL write got a=%0d m=%0d d=%h want a=%0d m=%0d d=%h",
                             bus.dst_wr_addr, bus.dst_wr_mod, bus.dst_wr_data, mon_e.a, mon_e.m, mon_e.d);
                end
            end
        end
    end
    task automatic chk(string name, longint act, longint want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask
    function automatic longint decode(int code, bit t, output bit bad);
        bad = 0;
        if (!t) return (code >= 2 ** (CW - 1)) ? code - 2 ** CW : code;
        case (code % 4)
            0: return 0;
            1: return 1;
            3: return -1;
            default: begin
                bad = 1;
                return 0;
            end
        endcase
    endfunction
    // mode 1: ch0 all -1; mode 2: ch0 alternates -32/+31; mode 3: ch2 may carry the bad ternary code
    task automatic fill(int mode, logic [NUM_CH-1:0] t);
        int v;
        for (int a = 0; a < N; a++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                v = $urandom_range(0, 2 ** CW - 1);
                if (t[c] && (v % 4) == 2 && !(mode == 3 && c == 2)) v = v ^ 1;
                if (mode == 1 && c == 0) v = 63;
                if (mode == 2 && c == 0) v = (a % 2) ? 31 : 32;
                if (mode == 3 && c == 2 && a % 4 == 1) v = 2 + 4 * $urandom_range(0, 15);
                src_mem[a][c*CW +: CW] = CW'(v);
            end
        end
    endtask
    task automatic push_exp(int first, int count, logic [NUM_CH-1:0] t);
        exp_t e;
        longint x;
        bit bad;
        int m;
        for (int j = 0; j < count; j++) begin
            m = (first + j) % (2 ** LOGI);
            for (int a = 0; a < N; a++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    x = decode(int'(src_mem[a][c*CW +: CW]), t[c], bad);
                    exp_err |= bad;
                    e.d[c*LOGQ +: LOGQ] = (x < 0) ? qm[m] - LOGQ'(-x) : LOGQ'(x);
                end
                e.a = LOGN'(a);
                e.m = LOGI'(m);
                sb.push_back(e);
            end
        end
    endtask
    task automatic sweep(string name, int first, int count, logic [NUM_CH-1:0] t, bit poke);
        int n;
        push_exp(first, count, t);
        bus.mod_first = LOGI'(first);
        bus.mod_count = (LOGI+1)'(count);
        bus.ch_ternary = t;
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        n = 1;
        if (count > 0) chk({name, "_busy"}, longint'(bus.busy), 1);
        while (!bus.done && n < 300) begin
            if (poke && n == 3) begin
                bus.cfg_we = 1;
                bus.cfg_idx = LOGI'(first);
                bus.cfg_q = ~qm[first];
            end
            if (poke && n == 4) bus.cfg_we = 0;
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, n, (count == 0) ? 2 : count * N + RD_LAT + 3);
        @(negedge clk);
        chk({name, "_done_pulse"}, longint'(bus.done), 0);
        chk({name, "_idle"}, longint'(bus.busy), 0);
        chk({name, "_drained"}, sb.size(), 0);
        chk({name, "_code_err"}, longint'(bus.code_err), longint'(exp_err));
    endtask
    initial begin
        int n;
        int nd;
        logic [NUM_CH-1:0] t;
        bus.cfg_we = 0;
        bus.cfg_idx = '0;
        bus.cfg_q = '0;
        bus.start = 0;
        bus.mod_first = '0;
        bus.mod_count = '0;
        bus.ch_ternary = '0;
        for (int a = 0; a < N; a++) src_mem[a] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_done", longint'(bus.done), 0);
        chk("rst_wea", longint'(bus.dst_wea), 0);
        chk("rst_code_err", longint'(bus.code_err), 0);
        chk("rst_rd_addr", longint'(bus.src_rd_addr), 0);
        chk("rst_wr_data_zero", longint'(|bus.dst_wr_data), 0);
        rst = 0;
        for (int i = 0; i < 2 ** LOGI; i++) begin
            qm[i] = LOGQ'({$urandom, $urandom}) | (LOGQ'(1) << (LOGQ - 1));
            if (i == 2) qm[i] = 54'h3FFFFFFFFFFFF1;
            bus.cfg_we = 1;
            bus.cfg_idx = LOGI'(i);
            bus.cfg_q = qm[i];
            @(negedge clk);
        end
        bus.cfg_we = 0;
        fill(1, 3'b000);
        sweep("minus_one", 2, 1, 3'b000, 0);
        fill(2, 3'b000);
        sweep("edges", 7, 1, 3'b000, 0);
        fill(0, 3'b100);
        sweep("ternary", 4, 1, 3'b100, 0);
        fill(0, 3'b010);
        sweep("wrap", 15, 2, 3'b010, 0);
        repeat (3) begin
            t = NUM_CH'($urandom);
            fill(0, t);
            sweep("random", $urandom_range(0, 15), $urandom_range(1, 3), t, 0);
        end
        sweep("zero_count", 3, 0, 3'b000, 0);
        fill(0, 3'b000);
        sweep("cfg_busy", 5, 1, 3'b000, 1);
        fill(0, 3'b000);
        sweep("cfg_kept", 5, 1, 3'b000, 0);
        fill(3, 3'b100);
        sweep("bad_code", 9, 1, 3'b100, 0);
        fill(0, 3'b100);
        sweep("sticky", 10, 1, 3'b100, 0);
        // abort on the sixth write of a two-modulus sweep
        fill(0, 3'b000);
        push_exp(0, 2, 3'b000);
        bus.mod_first = '0;
        bus.mod_count = (LOGI+1)'(2);
        bus.ch_ternary = '0;
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        n = 1;
        while (n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("abort_wea_before", longint'(bus.dst_wea), 1);
        rst = 1;
        @(negedge clk);
        chk("abort_wea_after", longint'(bus.dst_wea), 0);
        chk("abort_busy", longint'(bus.busy), 0);
        chk("abort_done", longint'(bus.done), 0);
        chk("abort_code_err", longint'(bus.code_err), 0);
        chk("abort_pending", sb.size(), 2 * N - 6);
        sb.delete();
        exp_err = 0;
        rst = 0;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("abort_no_done", nd, 0);
        fill(0, 3'b001);
        sweep("fresh", 1, 3, 3'b001, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
